ring_stop: RTL and testbench

Ring stop that joins one local master (core or bridge) to the LOTR request/response ring. Inserted between two tiles on the ring, it re-registers ring traffic, injects queued local requests into empty request slots, and removes responses addressed to its own CoreID into a local response queue. It is the stage that feeds a tile's RingReqIn/RingRspIn and consumes the previous tile's RingReqOut/RingRspOut.

---
 rtl/lotr_pkg.sv | 40 ++++
 rtl/ring_stop_fifo.sv | 63 ++++++
 rtl/ring_stop.sv | 171 +++++++++++++++++
 tb/tb_ring_stop.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lotr_pkg.sv
// Shared LOTR ring types: opcodes, ring slot payload and local response entry.
package lotr_pkg;

  localparam int unsigned RING_ID_W        = 8;
  localparam int unsigned RING_REQUESTOR_W = 10;
  localparam int unsigned RING_THREAD_W    = RING_REQUESTOR_W - RING_ID_W;
  localparam int unsigned RING_ADDR_W      = 32;
  localparam int unsigned RING_DATA_W      = 32;

  typedef enum logic [1:0] {
    RD     = 2'd0,
    WR     = 2'd1,
    RD_RSP = 2'd2,
    WR_RSP = 2'd3
  } t_opcode;

  typedef struct packed {
    logic                        valid;
    logic [RING_REQUESTOR_W-1:0] requestor;
    t_opcode                     opcode;
    logic [RING_ADDR_W-1:0]      address;
    logic [RING_DATA_W-1:0]      data;
  } t_ring_slot;

  typedef struct packed {
    logic [RING_THREAD_W-1:0] thread;
    t_opcode                  opcode;
    logic [RING_ADDR_W-1:0]   address;
    logic [RING_DATA_W-1:0]   data;
  } t_lcl_rsp;

  // Ring requestor ID is the stop's CoreID with the issuing thread in the low bits.
  function automatic logic [RING_REQUESTOR_W-1:0] make_requestor(
    input logic [RING_ID_W-1:0]     core_id,
    input logic [RING_THREAD_W-1:0] thread
  );
    return {core_id, thread};
  endfunction

endpackage

// File: rtl/ring_stop_fifo.sv
// Show-ahead synchronous FIFO; full/empty from occupancy, pushes on full and pops on empty ignored.
module ring_stop_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CNT_W'(DEPTH));
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Full/empty are start-of-cycle, so a same-cycle pop never makes room for a push.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/ring_stop.sv
// LOTR ring stop: re-registers both rings, injects local requests, captures own responses.
// Optional macro RING_STOP_ORPHAN_DROP_EN removes orphaned own requests and counts them in DropCnt.
module ring_stop
  import lotr_pkg::*;
#(
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic                        QClk,
  input  logic                        RstQnnnL,
  input  logic [RING_ID_W-1:0]        CoreID,
  input  logic                        RingReqInValidQ500H,
  input  logic [RING_REQUESTOR_W-1:0] RingReqInRequestorQ500H,
  input  t_opcode                     RingReqInOpcodeQ500H,
  input  logic [RING_ADDR_W-1:0]      RingReqInAddressQ500H,
  input  logic [RING_DATA_W-1:0]      RingReqInDataQ500H,
  input  logic                        RingRspInValidQ500H,
  input  logic [RING_REQUESTOR_W-1:0] RingRspInRequestorQ500H,
  input  t_opcode                     RingRspInOpcodeQ500H,
  input  logic [RING_ADDR_W-1:0]      RingRspInAddressQ500H,
  input  logic [RING_DATA_W-1:0]      RingRspInDataQ500H,
  output logic                        RingReqOutValidQ501H,
  output logic [RING_REQUESTOR_W-1:0] RingReqOutRequestorQ501H,
  output t_opcode                     RingReqOutOpcodeQ501H,
  output logic [RING_ADDR_W-1:0]      RingReqOutAddressQ501H,
  output logic [RING_DATA_W-1:0]      RingReqOutDataQ501H,
  output logic                        RingRspOutValidQ501H,
  output logic [RING_REQUESTOR_W-1:0] RingRspOutRequestorQ501H,
  output t_opcode                     RingRspOutOpcodeQ501H,
  output logic [RING_ADDR_W-1:0]      RingRspOutAddressQ501H,
  output logic [RING_DATA_W-1:0]      RingRspOutDataQ501H,
  input  logic                        LclReqValid,
  output logic                        LclReqReady,
  input  logic [RING_THREAD_W-1:0]    LclReqThread,
  input  t_opcode                     LclReqOpcode,
  input  logic [RING_ADDR_W-1:0]      LclReqAddress,
  input  logic [RING_DATA_W-1:0]      LclReqData,
  output logic                        LclRspValid,
  input  logic                        LclRspReady,
  output logic [RING_THREAD_W-1:0]    LclRspThread,
  output t_opcode                     LclRspOpcode,
  output logic [RING_ADDR_W-1:0]      LclRspAddress,
  output logic [RING_DATA_W-1:0]      LclRspData,
  output logic [7:0]                  DropCnt
);

  localparam int unsigned SLOT_W = $bits(t_ring_slot);
  localparam int unsigned RSP_W  = $bits(t_lcl_rsp);

  t_ring_slot req_in, rsp_in, req_head, req_push_data;
  t_ring_slot req_out_d, req_out_q, rsp_out_d, rsp_out_q;
  t_lcl_rsp   rsp_head, rsp_push_data;
  logic       req_pop, req_full, req_empty, slot_busy;
  logic       rsp_push, rsp_full, rsp_empty;

  assign req_in = '{valid: RingReqInValidQ500H, requestor: RingReqInRequestorQ500H,
                    opcode: RingReqInOpcodeQ500H, address: RingReqInAddressQ500H,
                    data: RingReqInDataQ500H};
  assign rsp_in = '{valid: RingRspInValidQ500H, requestor: RingRspInRequestorQ500H,
                    opcode: RingRspInOpcodeQ500H, address: RingRspInAddressQ500H,
                    data: RingRspInDataQ500H};

  assign req_push_data = '{valid: 1'b1, requestor: make_requestor(CoreID, LclReqThread),
                           opcode: LclReqOpcode, address: LclReqAddress, data: LclReqData};
  assign LclReqReady   = !req_full;

  ring_stop_fifo #(.WIDTH(SLOT_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk       (QClk),
    .rst_n     (RstQnnnL),
    .push      (LclReqValid),
    .push_data (req_push_data),
    .pop       (req_pop),
    .head_data (req_head),
    .full      (req_full),
    .empty     (req_empty)
  );

  assign rsp_push_data = '{thread: rsp_in.requestor[RING_THREAD_W-1:0], opcode: rsp_in.opcode,
                           address: rsp_in.address, data: rsp_in.data};

  ring_stop_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk       (QClk),
    .rst_n     (RstQnnnL),
    .push      (rsp_push),
    .push_data (rsp_push_data),
    .pop       (LclRspReady),
    .head_data (rsp_head),
    .full      (rsp_full),
    .empty     (rsp_empty)
  );

  assign LclRspValid   = !rsp_empty;
  assign LclRspThread  = rsp_head.thread;
  assign LclRspOpcode  = rsp_head.opcode;
  assign LclRspAddress = rsp_head.address;
  assign LclRspData    = rsp_head.data;

`ifdef RING_STOP_ORPHAN_DROP_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       orphan;

  assign orphan = req_in.valid
               && (req_in.requestor[RING_REQUESTOR_W-1 -: RING_ID_W] == CoreID)
               && (req_in.opcode == RD || req_in.opcode == WR);
`endif

  // Request slot: orphan removal, then pass-through, then injection into an empty slot.
  always_comb begin
    req_out_d = '0;
    req_pop   = 1'b0;
    slot_busy = req_in.valid;
`ifdef RING_STOP_ORPHAN_DROP_EN
    drop_cnt_d = drop_cnt_q;
    if (orphan) begin
      slot_busy = 1'b0;
      if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
`endif
    if (slot_busy) begin
      req_out_d = req_in;
    end else if (!req_empty) begin
      req_out_d = req_head;
      req_pop   = 1'b1;
    end
  end

  // Response slot: own responses captured unless the local queue is full, then they recirculate.
  always_comb begin
    rsp_out_d = '0;
    rsp_push  = 1'b0;
    if (rsp_in.valid) begin
      if ((rsp_in.requestor[RING_REQUESTOR_W-1 -: RING_ID_W] == CoreID) && !rsp_full) begin
        rsp_push = 1'b1;
      end else begin
        rsp_out_d = rsp_in;
      end
    end
  end

  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) begin
      req_out_q <= '0;
      rsp_out_q <= '0;
    end else begin
      req_out_q <= req_out_d;
      rsp_out_q <= rsp_out_d;
    end
  end

`ifdef RING_STOP_ORPHAN_DROP_EN
  always_ff @(posedge QClk or negedge RstQnnnL) begin
    if (!RstQnnnL) drop_cnt_q <= '0;
    else           drop_cnt_q <= drop_cnt_d;
  end
  assign DropCnt = drop_cnt_q;
`else
  assign DropCnt = '0;
`endif

  assign RingReqOutValidQ501H     = req_out_q.valid;
  assign RingReqOutRequestorQ501H = req_out_q.requestor;
  assign RingReqOutOpcodeQ501H    = req_out_q.opcode;
  assign RingReqOutAddressQ501H   = req_out_q.address;
  assign RingReqOutDataQ501H      = req_out_q.data;
  assign RingRspOutValidQ501H     = rsp_out_q.valid;
  assign RingRspOutRequestorQ501H = rsp_out_q.requestor;
  assign RingRspOutOpcodeQ501H    = rsp_out_q.opcode;
  assign RingRspOutAddressQ501H   = rsp_out_q.address;
  assign RingRspOutDataQ501H      = rsp_out_q.data;

endmodule

// File: tb/tb_ring_stop.sv
// Scoreboard bench for ring_stop: directed stimulus pushes expectations, a negedge monitor checks them.
module tb_ring_stop;
  import lotr_pkg::*;

  localparam logic [7:0] CORE = 8'd3;

  logic        QClk = 1'b0;
  logic        RstQnnnL;
  logic [7:0]  CoreID;
  logic        RingReqInValidQ500H, RingRspInValidQ500H;
  logic [9:0]  RingReqInRequestorQ500H, RingRspInRequestorQ500H;
  t_opcode     RingReqInOpcodeQ500H, RingRspInOpcodeQ500H;
  logic [31:0] RingReqInAddressQ500H, RingReqInDataQ500H, RingRspInAddressQ500H, RingRspInDataQ500H;
  logic        RingReqOutValidQ501H, RingRspOutValidQ501H;
  logic [9:0]  RingReqOutRequestorQ501H, RingRspOutRequestorQ501H;
  t_opcode     RingReqOutOpcodeQ501H, RingRspOutOpcodeQ501H;
  logic [31:0] RingReqOutAddressQ501H, RingReqOutDataQ501H, RingRspOutAddressQ501H, RingRspOutDataQ501H;
  logic        LclReqValid, LclReqReady, LclRspValid, LclRspReady;
  logic [1:0]  LclReqThread, LclRspThread;
  t_opcode     LclReqOpcode, LclRspOpcode;
  logic [31:0] LclReqAddress, LclReqData, LclRspAddress, LclRspData;
  logic [7:0]  DropCnt;

  typedef struct { t_ring_slot s; int cyc; } exp_slot_t;
  typedef struct { t_lcl_rsp r; int cyc; } exp_lcl_t;

  exp_slot_t exp_req_q[$];
  exp_slot_t exp_rsp_q[$];
  exp_lcl_t  exp_lcl_q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int k;

  always #5 QClk = ~QClk;
  always @(posedge QClk) cyc <= cyc + 1;

  ring_stop #(.REQ_DEPTH(4), .RSP_DEPTH(4)) dut (
    .QClk(QClk), .RstQnnnL(RstQnnnL), .CoreID(CoreID),
    .RingReqInValidQ500H(RingReqInValidQ500H), .RingReqInRequestorQ500H(RingReqInRequestorQ500H),
    .RingReqInOpcodeQ500H(RingReqInOpcodeQ500H), .RingReqInAddressQ500H(RingReqInAddressQ500H),
    .RingReqInDataQ500H(RingReqInDataQ500H),
    .RingRspInValidQ500H(RingRspInValidQ500H), .RingRspInRequestorQ500H(RingRspInRequestorQ500H),
    .RingRspInOpcodeQ500H(RingRspInOpcodeQ500H), .RingRspInAddressQ500H(RingRspInAddressQ500H),
    .RingRspInDataQ500H(RingRspInDataQ500H),
    .RingReqOutValidQ501H(RingReqOutValidQ501H), .RingReqOutRequestorQ501H(RingReqOutRequestorQ501H),
    .RingReqOutOpcodeQ501H(RingReqOutOpcodeQ501H), .RingReqOutAddressQ501H(RingReqOutAddressQ501H),
    .RingReqOutDataQ501H(RingReqOutDataQ501H),
    .RingRspOutValidQ501H(RingRspOutValidQ501H), .RingRspOutRequestorQ501H(RingRspOutRequestorQ501H),
    .RingRspOutOpcodeQ501H(RingRspOutOpcodeQ501H), .RingRspOutAddressQ501H(RingRspOutAddressQ501H),
    .RingRspOutDataQ501H(RingRspOutDataQ501H),
    .LclReqValid(LclReqValid), .LclReqReady(LclReqReady), .LclReqThread(LclReqThread),
    .LclReqOpcode(LclReqOpcode), .LclReqAddress(LclReqAddress), .LclReqData(LclReqData),
    .LclRspValid(LclRspValid), .LclRspReady(LclRspReady), .LclRspThread(LclRspThread),
    .LclRspOpcode(LclRspOpcode), .LclRspAddress(LclRspAddress), .LclRspData(LclRspData),
    .DropCnt(DropCnt)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge QClk);
    #2;
  endtask

  task automatic set_req_in(input logic v, input logic [9:0] r, input t_opcode op,
                            input logic [31:0] a, input logic [31:0] d);
    RingReqInValidQ500H = v; RingReqInRequestorQ500H = r; RingReqInOpcodeQ500H = op;
    RingReqInAddressQ500H = a; RingReqInDataQ500H = d;
  endtask

  task automatic set_rsp_in(input logic v, input logic [9:0] r, input t_opcode op,
                            input logic [31:0] a, input logic [31:0] d);
    RingRspInValidQ500H = v; RingRspInRequestorQ500H = r; RingRspInOpcodeQ500H = op;
    RingRspInAddressQ500H = a; RingRspInDataQ500H = d;
  endtask

  task automatic lcl_req(input logic v, input logic [1:0] th, input t_opcode op,
                         input logic [31:0] a, input logic [31:0] d);
    LclReqValid = v; LclReqThread = th; LclReqOpcode = op; LclReqAddress = a; LclReqData = d;
  endtask

  task automatic exp_req(input logic [9:0] r, input t_opcode op, input logic [31:0] a,
                         input logic [31:0] d, input int c);
    exp_slot_t e;
    e.s = '{valid: 1'b1, requestor: r, opcode: op, address: a, data: d};
    e.cyc = c;
    exp_req_q.push_back(e);
  endtask

  task automatic exp_rsp(input logic [9:0] r, input t_opcode op, input logic [31:0] a,
                         input logic [31:0] d, input int c);
    exp_slot_t e;
    e.s = '{valid: 1'b1, requestor: r, opcode: op, address: a, data: d};
    e.cyc = c;
    exp_rsp_q.push_back(e);
  endtask

  task automatic exp_lcl(input logic [1:0] th, input t_opcode op, input logic [31:0] a,
                         input logic [31:0] d, input int c);
    exp_lcl_t e;
    e.r = '{thread: th, opcode: op, address: a, data: d};
    e.cyc = c;
    exp_lcl_q.push_back(e);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_out"}, {RingReqOutValidQ501H, RingReqOutRequestorQ501H, RingReqOutOpcodeQ501H,
                              RingReqOutAddressQ501H, RingReqOutDataQ501H}, '0);
    check({tag, "_rsp_out"}, {RingRspOutValidQ501H, RingRspOutRequestorQ501H, RingRspOutOpcodeQ501H,
                              RingRspOutAddressQ501H, RingRspOutDataQ501H}, '0);
    check({tag, "_lcl_rsp_valid"}, LclRspValid, 1'b0);
    check({tag, "_lcl_rsp_payload"}, {LclRspThread, LclRspOpcode, LclRspAddress, LclRspData}, '0);
    check({tag, "_lcl_req_ready"}, LclReqReady, 1'b1);
    check({tag, "_drop_cnt"}, DropCnt, 8'd0);
  endtask

  // Monitor: every presented output is matched against the head of its expectation queue.
  always @(negedge QClk) begin : monitor
    t_ring_slot ro, so;
    t_lcl_rsp   lo;
    exp_slot_t  es;
    exp_lcl_t   el;
    if (RstQnnnL) begin
      ro = '{RingReqOutValidQ501H, RingReqOutRequestorQ501H, RingReqOutOpcodeQ501H,
             RingReqOutAddressQ501H, RingReqOutDataQ501H};
      so = '{RingRspOutValidQ501H, RingRspOutRequestorQ501H, RingRspOutOpcodeQ501H,
             RingRspOutAddressQ501H, RingRspOutDataQ501H};
      lo = '{LclRspThread, LclRspOpcode, LclRspAddress, LclRspData};
      if (ro.valid) begin
        if (exp_req_q.size() == 0) check("req_out_unexpected", ro, '0);
        else begin
          es = exp_req_q.pop_front();
          check("req_out_slot", ro, es.s);
          check("req_out_cycle", cyc, es.cyc);
        end
      end else check("req_out_idle_zero", ro, '0);
      if (so.valid) begin
        if (exp_rsp_q.size() == 0) check("rsp_out_unexpected", so, '0);
        else begin
          es = exp_rsp_q.pop_front();
          check("rsp_out_slot", so, es.s);
          check("rsp_out_cycle", cyc, es.cyc);
        end
      end else check("rsp_out_idle_zero", so, '0);
      if (LclRspValid && LclRspReady) begin
        if (exp_lcl_q.size() == 0) check("lcl_rsp_unexpected", lo, '0);
        else begin
          el = exp_lcl_q.pop_front();
          check("lcl_rsp_payload", lo, el.r);
          check("lcl_rsp_cycle", cyc, el.cyc);
        end
      end
    end
  end

  initial begin
    RstQnnnL = 1'b0;
    CoreID = CORE;
    LclRspReady = 1'b1;
    set_req_in(1'b0, '0, RD, '0, '0);
    set_rsp_in(1'b0, '0, RD, '0, '0);
    lcl_req(1'b0, '0, RD, '0, '0);
    repeat (2) tick();
    check_reset("reset");
    RstQnnnL = 1'b1;
    repeat (2) tick();

    // Single local request on an idle ring.
    k = cyc;
    lcl_req(1'b1, 2'd2, RD, 32'h0000_1000, 32'h0);
    exp_req(10'h00E, RD, 32'h0000_1000, 32'h0, k + 2);
    tick();
    lcl_req(1'b0, '0, RD, '0, '0);
    repeat (4) tick();

    // Ten pass-through requests; two queued locals wait for the first empty slots.
    k = cyc;
    for (int i = 0; i < 10; i++) begin
      set_req_in(1'b1, 10'(80 + i), (i % 2 == 1) ? WR : RD, 32'hA000 + i, 32'h1111_0000 + i);
      exp_req(10'(80 + i), (i % 2 == 1) ? WR : RD, 32'hA000 + i, 32'h1111_0000 + i, k + i + 1);
      if (i == 0) lcl_req(1'b1, 2'd0, WR, 32'h3000, 32'hC0DE_0000);
      else if (i == 1) lcl_req(1'b1, 2'd1, RD, 32'h3004, 32'h0);
      else lcl_req(1'b0, '0, RD, '0, '0);
      tick();
    end
    set_req_in(1'b0, '0, RD, '0, '0);
    exp_req(10'h00C, WR, 32'h3000, 32'hC0DE_0000, k + 11);
    exp_req(10'h00D, RD, 32'h3004, 32'h0, k + 12);
    repeat (5) tick();

    // Own response captured, foreign response passes.
    k = cyc;
    set_rsp_in(1'b1, 10'h00D, RD_RSP, 32'h2000, 32'hDEAD_BEEF);
    exp_lcl(2'd1, RD_RSP, 32'h2000, 32'hDEAD_BEEF, k + 1);
    tick();
    check("capture_lcl_rsp_valid", LclRspValid, 1'b1);
    check("capture_ring_rsp_empty", RingRspOutValidQ501H, 1'b0);
    set_rsp_in(1'b1, 10'h101, WR_RSP, 32'h2004, 32'h5555);
    exp_rsp(10'h101, WR_RSP, 32'h2004, 32'h5555, k + 2);
    tick();
    set_rsp_in(1'b0, '0, RD, '0, '0);
    repeat (4) tick();

    // Both FIFOs fill: 5th own response recirculates, 5th local request refused.
    LclRspReady = 1'b0;
    k = cyc;
    for (int i = 0; i < 6; i++) begin
      set_req_in(1'b1, 10'(96 + i), WR, 32'hB000 + i, 32'h2222_0000 + i);
      exp_req(10'(96 + i), WR, 32'hB000 + i, 32'h2222_0000 + i, k + i + 1);
      if (i < 5) begin
        lcl_req(1'b1, 2'(i), WR, 32'h4000 + 4 * i, 32'h3333_0000 + i);
        set_rsp_in(1'b1, {CORE, 2'(i)}, RD_RSP, 32'h5000 + i, 32'h4444_0000 + i);
        if (i < 4) exp_lcl(2'(i), RD_RSP, 32'h5000 + i, 32'h4444_0000 + i, k + 6 + i);
        else exp_rsp({CORE, 2'(i)}, RD_RSP, 32'h5000 + i, 32'h4444_0000 + i, k + 5);
      end else begin
        lcl_req(1'b0, '0, RD, '0, '0);
        set_rsp_in(1'b0, '0, RD, '0, '0);
      end
      if (i == 3) check("req_ready_at_3", LclReqReady, 1'b1);
      if (i == 4) check("req_ready_full", LclReqReady, 1'b0);
      tick();
    end
    set_req_in(1'b0, '0, RD, '0, '0);
    LclRspReady = 1'b1;
    for (int i = 0; i < 4; i++) exp_req({CORE, 2'(i)}, WR, 32'h4000 + 4 * i, 32'h3333_0000 + i, k + 7 + i);
    repeat (8) tick();

    // 300 orphan requests with one local request queued behind them.
    k = cyc;
    lcl_req(1'b1, 2'd3, RD, 32'h6000, 32'h0);
`ifdef RING_STOP_ORPHAN_DROP_EN
    exp_req(10'h00F, RD, 32'h6000, 32'h0, k + 2);
`endif
    for (int i = 0; i < 300; i++) begin
      set_req_in(1'b1, 10'h00C, WR, 32'h7000 + i, 32'(i));
`ifdef RING_STOP_ORPHAN_DROP_EN
      if (i == 100) check("drop_cnt_100", DropCnt, 8'd100);
`else
      exp_req(10'h00C, WR, 32'h7000 + i, 32'(i), k + i + 1);
`endif
      if (i == 1) lcl_req(1'b0, '0, RD, '0, '0);
      tick();
    end
    set_req_in(1'b0, '0, RD, '0, '0);
`ifdef RING_STOP_ORPHAN_DROP_EN
    check("drop_cnt_saturated", DropCnt, 8'd255);
`else
    exp_req(10'h00F, RD, 32'h6000, 32'h0, k + 301);
    check("drop_cnt_disabled", DropCnt, 8'd0);
`endif
    repeat (4) tick();

    // Reset while both FIFOs hold two entries.
    LclRspReady = 1'b0;
    k = cyc;
    set_req_in(1'b1, 10'h123, RD, 32'h9000, 32'h1);
    exp_req(10'h123, RD, 32'h9000, 32'h1, k + 1);
    lcl_req(1'b1, 2'd0, RD, 32'h8000, 32'h0);
    set_rsp_in(1'b1, 10'h00E, RD_RSP, 32'h8100, 32'hAAAA);
    tick();
    set_req_in(1'b1, 10'h124, RD, 32'h9004, 32'h2);
    lcl_req(1'b1, 2'd1, WR, 32'h8004, 32'h7);
    set_rsp_in(1'b1, 10'h00F, WR_RSP, 32'h8104, 32'hBBBB);
    tick();
    set_req_in(1'b0, '0, RD, '0, '0);
    lcl_req(1'b0, '0, RD, '0, '0);
    set_rsp_in(1'b0, '0, RD, '0, '0);
    RstQnnnL = 1'b0;
    #1;
    check_reset("mid_reset");
    repeat (2) tick();
    RstQnnnL = 1'b1;
    LclRspReady = 1'b1;
    repeat (6) tick();
    check("post_reset_req_ready", LclReqReady, 1'b1);
    check("post_reset_lcl_rsp_valid", LclRspValid, 1'b0);

    check("req_queue_drained", exp_req_q.size(), 0);
    check("rsp_queue_drained", exp_rsp_q.size(), 0);
    check("lcl_queue_drained", exp_lcl_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
